// File: rtl/definesPkg.sv
// Shared AHB encodings, slave FSM states and ROM image
// for the ahb_slave_mem block.
package definesPkg;

  typedef enum logic [1:0] {
    IDLE, BUSY, NON_SEQ, SEQ
  } htrans_t;

  typedef enum logic [2:0] {
    SINGLE, INCR, WRAP4, INCR4,
    WRAP8, INCR8, WRAP16, INCR16
  } hburst_t;

  typedef enum logic [2:0] {
    SZ_BYTE, SZ_HALF, SZ_WORD
  } hsize_t;

  localparam logic OKAY  = 1'b0;
  localparam logic ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE, ST_ACCESS, ST_ERR1, ST_ERR2
  } state_t;

  localparam int ROM_MAX = 16;
  localparam logic [8*ROM_MAX-1:0] ROM_INIT =
    128'h0F0E0D0C_0B0A0908_07060504_CAFEF00D;

  function automatic logic [3:0] lane_mask(
    input logic [2:0] size,
    input logic [1:0] a
  );
    logic [3:0] m;
    case (size)
      3'd0:    m = 4'b0001 << a;
      3'd1:    m = a[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/slave_mem_array.sv
// Word-addressed storage with per-byte write enables
// and asynchronous read; contents survive reset.
module slave_mem_array #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [3:0]    i_be,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [2**AW];

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_be[b])
          r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-Lite memory slave: wait-state insertion, read-only
// ROM window and two-cycle ERROR response for bad transfers.
module ahb_slave_mem
  import definesPkg::*;
#(
  parameter int WAIT_STATES = 0,
  parameter int MEM_BYTES   = 1024,
  parameter int ROM_BYTES   = 4
) (
  input  logic        HCLK,
  input  logic        reset,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA
);

  localparam int AW = $clog2(MEM_BYTES / 4);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_wait;
  logic [2:0]  w_wait_nxt;
  logic [9:0]  r_addr;
  logic        r_write;
  logic [2:0]  r_size;
  logic [31:0] r_hrdata;

  logic          w_ready;
  logic          w_take;
  logic          w_illegal;
  logic          w_we;
  logic          w_rd_done;
  logic [AW-1:0] w_widx;
  logic [31:0]   w_mem_rdata;
  logic [31:0]   w_rdata;
  logic          w_unused;

  assign w_unused = ^{HBURST, HADDR[31:10]};

  assign w_ready = (r_state == ST_ACCESS) ? (r_wait == 3'd0)
                 : (r_state != ST_ERR1);

  // a new address phase is only looked at while we are ready
  assign w_take = w_ready && HSEL && HREADY &&
                  (HTRANS == NON_SEQ || HTRANS == SEQ);

  assign w_illegal =
      (HWRITE && int'(HADDR[9:0]) < ROM_BYTES) ||
      (HSIZE > 3'd2) ||
      (HSIZE == 3'd1 && HADDR[0]) ||
      (HSIZE == 3'd2 && HADDR[1:0] != 2'd0);

  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait;
    case (r_state)
      ST_ERR1:   w_state_nxt = ST_ERR2;
      ST_ACCESS: if (r_wait != 3'd0) w_wait_nxt = r_wait - 3'd1;
      default:   ;
    endcase
    if (w_ready) begin
      w_state_nxt = ST_IDLE;
      if (w_take) begin
        w_state_nxt = w_illegal ? ST_ERR1 : ST_ACCESS;
        w_wait_nxt  = w_illegal ? 3'd0 : 3'(WAIT_STATES);
      end
    end
  end

  always_ff @(posedge HCLK or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_wait  <= 3'd0;
      r_addr  <= 10'd0;
      r_write <= 1'b0;
      r_size  <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_wait  <= w_wait_nxt;
      if (w_take) begin
        r_addr  <= HADDR[9:0];
        r_write <= HWRITE;
        r_size  <= HSIZE;
      end
    end
  end

  assign w_widx    = r_addr[AW+1:2];
  assign w_we      = (r_state == ST_ACCESS) && w_ready && r_write;
  assign w_rd_done = (r_state == ST_ACCESS) && w_ready && !r_write;

  slave_mem_array #(.AW(AW)) u_mem (
    .clk     (HCLK),
    .i_we    (w_we),
    .i_be    (lane_mask(r_size, r_addr[1:0])),
    .i_addr  (w_widx),
    .i_wdata (HWDATA),
    .o_rdata (w_mem_rdata)
  );

  // ROM bytes come straight from the constant image
  always_comb begin
    w_rdata = w_mem_rdata;
    for (int b = 0; b < 4; b++) begin
      if (4 * int'(w_widx) + b < ROM_BYTES)
        w_rdata[8*b +: 8] = ROM_INIT[8*(4*int'(w_widx)+b) +: 8];
    end
  end

  always_ff @(posedge HCLK or negedge reset) begin
    if (!reset)
      r_hrdata <= 32'd0;
    else if (w_rd_done)
      r_hrdata <= w_rdata;
  end

  assign HRDATA    = w_rd_done ? w_rdata : r_hrdata;
  assign HREADYOUT = w_ready;
  assign HRESP     = (r_state == ST_ERR1 || r_state == ST_ERR2)
                   ? ERROR : OKAY;

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Randomised AHB master against a byte-level memory model,
// covering a zero-wait and a two-wait-state slave.
module tb_ahb_slave_mem;
  import definesPkg::*;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wr;
    logic [2:0]  size;
    logic [1:0]  trans;
    logic        sel;
    logic [2:0]  burst;
  } xfer_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] haddr, hwdata;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize, hburst;
  logic        hsel0, hsel2;
  logic        which;
  logic        hready;
  logic        ro0, rs0, ro2, rs2;
  logic [31:0] rd0, rd2;

  int checks = 0;
  int errors = 0;

  xfer_t       q[$];
  logic [7:0]  mdl[1024];
  logic        known[1024];
  logic [31:0] last_v, last_m;

  always #5 clk = ~clk;

  assign hready = which ? ro2 : ro0;

  ahb_slave_mem #(.WAIT_STATES(0)) dut0 (
    .HCLK(clk), .reset(rst_n), .HSEL(hsel0),
    .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite),
    .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata),
    .HREADY(hready), .HREADYOUT(ro0), .HRESP(rs0),
    .HRDATA(rd0)
  );

  ahb_slave_mem #(.WAIT_STATES(2)) dut2 (
    .HCLK(clk), .reset(rst_n), .HSEL(hsel2),
    .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite),
    .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata),
    .HREADY(hready), .HREADYOUT(ro2), .HRESP(rs2),
    .HRDATA(rd2)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic model_init();
    logic [127:0] rom;
    rom = ROM_INIT;
    for (int i = 0; i < 1024; i++) begin
      mdl[i]   = 8'h00;
      known[i] = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      mdl[i]   = rom[8*i +: 8];
      known[i] = 1'b1;
    end
    last_v = 32'd0;
    last_m = 32'hFFFF_FFFF;
  endtask

  function automatic logic legal(input xfer_t x);
    int off;
    off = int'(x.addr[9:0]);
    if (x.size > 3'd2) return 1'b0;
    if (off % (1 << x.size) != 0) return 1'b0;
    if (x.wr && off < 4) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_wr(input xfer_t x);
    int off;
    for (int k = 0; k < (1 << x.size); k++) begin
      off        = int'(x.addr[9:0]) + k;
      mdl[off]   = x.wdata[8*(off%4) +: 8];
      known[off] = 1'b1;
    end
  endtask

  task automatic model_rd(input logic [31:0] a,
                          output logic [31:0] v,
                          output logic [31:0] m);
    int base;
    base = 4 * int'(a[9:2]);
    for (int b = 0; b < 4; b++) begin
      v[8*b +: 8] = mdl[base+b];
      m[8*b +: 8] = known[base+b] ? 8'hFF : 8'h00;
    end
  endtask

  task automatic push(input logic [31:0] a, input logic wr,
                      input logic [2:0] sz, input logic [1:0] tr,
                      input logic [31:0] wd,
                      input logic [2:0] bst);
    xfer_t x;
    x.addr = a; x.wr = wr; x.size = sz; x.trans = tr;
    x.wdata = wd; x.sel = 1'b1; x.burst = bst;
    q.push_back(x);
  endtask

  task automatic put(input xfer_t x, input logic v);
    if (v) begin
      haddr  = x.addr;
      hwrite = x.wr;
      hsize  = x.size;
      htrans = x.trans;
      hburst = x.burst;
      hsel0  = x.sel && !which;
      hsel2  = x.sel && which;
    end else begin
      htrans = IDLE;
      hsel0  = 1'b0;
      hsel2  = 1'b0;
    end
  endtask

  task automatic run();
    xfer_t       ap, dp;
    logic        apv, dpv, rdy, rsp;
    logic [31:0] rd, ev, em;
    int          wcnt, ecnt, cyc, ws;
    ws   = which ? 2 : 0;
    apv  = q.size() > 0;
    if (apv) ap = q.pop_front();
    put(ap, apv);
    dpv  = 1'b0;
    wcnt = 0;
    ecnt = 0;
    cyc  = 0;
    while ((apv || dpv) && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      rdy = which ? ro2 : ro0;
      rsp = which ? rs2 : rs0;
      rd  = which ? rd2 : rd0;
      if (dpv && legal(dp)) begin
        chk("ok_resp", 32'(rsp), 32'(OKAY));
        if (!rdy) begin
          wcnt++;
          chk("hold", rd & last_m, last_v & last_m);
        end else begin
          chk("wait_cnt", wcnt, ws);
          if (!dp.wr) begin
            model_rd(dp.addr, ev, em);
            chk("rdata", rd & em, ev & em);
            last_v = ev;
            last_m = em;
          end else begin
            chk("hold", rd & last_m, last_v & last_m);
            model_wr(dp);
          end
        end
      end else if (dpv) begin
        chk("err_rdy", 32'(rdy), 32'(ecnt != 0));
        chk("err_resp", 32'(rsp), 32'(ERROR));
        chk("hold", rd & last_m, last_v & last_m);
        ecnt++;
      end else begin
        chk("idle_rdy", 32'(rdy), 32'd1);
        chk("idle_resp", 32'(rsp), 32'(OKAY));
      end
      if (wcnt > 16 || ecnt > 2) begin
        chk("stall", wcnt, ws);
        break;
      end
      @(posedge clk);
      #1;
      if (rdy) begin
        dpv  = apv && ap.sel &&
               (ap.trans == NON_SEQ || ap.trans == SEQ);
        dp   = ap;
        wcnt = 0;
        ecnt = 0;
        hwdata = dpv ? dp.wdata : $urandom;
        apv  = q.size() > 0;
        if (apv) ap = q.pop_front();
        put(ap, apv);
      end
    end
    chk("done", 32'(apv || dpv), 32'd0);
    q.delete();
    put(ap, 1'b0);
  endtask

  task automatic gen_rand(input int n);
    xfer_t x;
    int    r;
    for (int i = 0; i < n; i++) begin
      x.size  = 3'($urandom_range(0, 3));
      x.addr  = 32'($urandom_range(0, 127));
      if ($urandom_range(0, 3) != 0 && x.size < 3'd3)
        x.addr = x.addr & ~((32'd1 << x.size) - 32'd1);
      if ($urandom_range(0, 7) == 0)
        x.addr = x.addr | (32'($urandom_range(1, 7)) << 10);
      x.wr    = 1'($urandom_range(0, 1));
      x.wdata = $urandom;
      r       = $urandom_range(0, 9);
      x.trans = (r == 0) ? IDLE : (r == 1) ? BUSY
              : (r < 6) ? NON_SEQ : SEQ;
      x.sel   = $urandom_range(0, 15) != 0;
      x.burst = 3'($urandom_range(0, 7));
      q.push_back(x);
    end
  endtask

  initial begin
    which  = 1'b0;
    haddr  = 32'd0;
    hwdata = 32'd0;
    htrans = IDLE;
    hwrite = 1'b0;
    hsize  = 3'd0;
    hburst = SINGLE;
    hsel0  = 1'b0;
    hsel2  = 1'b0;
    rst_n  = 1'b0;
    model_init();
    repeat (3) @(negedge clk);
    chk("rst_rdy0", 32'(ro0), 32'd1);
    chk("rst_resp0", 32'(rs0), 32'd0);
    chk("rst_rdata0", rd0, 32'd0);
    chk("rst_rdy2", 32'(ro2), 32'd1);
    chk("rst_resp2", 32'(rs2), 32'd0);
    chk("rst_rdata2", rd2, 32'd0);
    rst_n = 1'b1;

    push(32'h010, 1'b1, 3'd2, NON_SEQ, 32'hDEADBEEF, SINGLE);
    push(32'h010, 1'b0, 3'd2, NON_SEQ, 32'h0, SINGLE);
    push(32'h002, 1'b1, 3'd0, NON_SEQ, 32'h00550000, SINGLE);
    push(32'h000, 1'b0, 3'd2, NON_SEQ, 32'h0, SINGLE);
    for (int i = 0; i < 4; i++)
      push(32'h100 + 32'(4*i), 1'b1, 3'd2,
           (i == 0) ? NON_SEQ : SEQ, 32'(i + 1), INCR4);
    for (int i = 0; i < 4; i++)
      push(32'h100 + 32'(4*i), 1'b0, 3'd2,
           (i == 0) ? NON_SEQ : SEQ, 32'h0, INCR4);
    push(32'h020, 1'b1, 3'd2, NON_SEQ, 32'h11223344, SINGLE);
    push(32'h021, 1'b1, 3'd0, NON_SEQ, 32'h0000AB00, SINGLE);
    push(32'h020, 1'b0, 3'd2, NON_SEQ, 32'h0, SINGLE);
    push(32'h023, 1'b0, 3'd1, NON_SEQ, 32'h0, SINGLE);
    push(32'h030, 1'b1, 3'd1, NON_SEQ, 32'h0000BEAD, SINGLE);
    push(32'h030, 1'b0, 3'd2, NON_SEQ, 32'h0, SINGLE);
    push(32'h034, 1'b0, 3'd2, BUSY, 32'h0, SINGLE);
    push(32'h410, 1'b0, 3'd2, NON_SEQ, 32'h0, SINGLE);
    push(32'h044, 1'b1, 3'd4, NON_SEQ, 32'h0, SINGLE);
    run();
    chk("abw_word", {mdl[35], mdl[34], mdl[33], mdl[32]},
        32'h1122AB44);

    gen_rand(300);
    run();

    push(32'h040, 1'b1, 3'd2, NON_SEQ, 32'h5A5A1234, SINGLE);
    run();
    haddr  = 32'h040;
    hwrite = 1'b1;
    hsize  = 3'd2;
    htrans = NON_SEQ;
    hsel0  = 1'b1;
    @(posedge clk);
    #1;
    htrans = IDLE;
    hsel0  = 1'b0;
    hwdata = 32'hFFFF0000;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_rdy", 32'(ro0), 32'd1);
    chk("abort_resp", 32'(rs0), 32'd0);
    chk("abort_rdata", rd0, 32'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    last_v = 32'd0;
    last_m = 32'hFFFF_FFFF;
    push(32'h040, 1'b0, 3'd2, NON_SEQ, 32'h0, SINGLE);
    run();

    which = 1'b1;
    model_init();
    push(32'h050, 1'b1, 3'd2, NON_SEQ, 32'hA5A5C3C3, SINGLE);
    push(32'h050, 1'b0, 3'd2, NON_SEQ, 32'h0, SINGLE);
    push(32'h003, 1'b1, 3'd0, NON_SEQ, 32'h0, SINGLE);
    gen_rand(150);
    run();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_slave_mem.md
AHB_SLAVE_MEM -- requirements
Module: ahb_slave_mem

Interface
REQ-001 Parameter WAIT_STATES, default 0: HREADYOUT-low cycles inserted in each OKAY data phase; legal range 0..7.
REQ-002 Parameter MEM_BYTES, default 1024: slave region size; the offset is HADDR[9:0].
REQ-003 Parameter ROM_BYTES, default 4: byte offsets 0..ROM_BYTES-1 are read-only.
REQ-004 HCLK  in  1  bus clock; one clock, all state on the rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 HSEL  in  1  slave select from the decoder.
REQ-007 HADDR  in  32  byte address.
REQ-008 HTRANS  in  2  transfer type: IDLE, BUSY, NON_SEQ, SEQ.
REQ-009 HWRITE  in  1  1 = write.
REQ-010 HSIZE  in  3  transfer size: 0 byte, 1 half, 2 word.
REQ-011 HBURST  in  3  burst type; informational only.
REQ-012 HWDATA  in  32  write data, valid in the data phase.
REQ-013 HREADY  in  1  bus-level ready; qualifies the address phase.
REQ-014 HREADYOUT  out  1  slave ready.
REQ-015 HRESP  out  1  0 OKAY, 1 ERROR.
REQ-016 HRDATA  out  32  read data.

Function
REQ-017 An address phase SHALL be accepted when HSEL && HREADY && HTRANS is NON_SEQ or SEQ; the block then registers HADDR[9:0], HWRITE and HSIZE.
REQ-018 IDLE and BUSY transfers SHALL be accepted with a zero-wait OKAY response and SHALL cause no memory access.
REQ-019 The FSM SHALL have the states IDLE, ACCESS, ERR1 and ERR2:
- IDLE->ACCESS on an accepted legal transfer.
- IDLE->ERR1 on an accepted illegal transfer.
- ACCESS->IDLE, or directly to the next ACCESS/ERR1, when the wait counter reaches 0 and HREADYOUT=1.
- ERR1->ERR2 unconditionally.
- ERR2->IDLE, or to the next ACCESS/ERR1.
REQ-020 A transfer SHALL be illegal if any of the following holds:
- HWRITE=1 with an offset < ROM_BYTES;
- HSIZE > 2;
- the address is misaligned (half-word with HADDR[0]=1, or word with HADDR[1:0]!=0).
REQ-021 An illegal transfer SHALL get a two-cycle error response: ERR1 drives HREADYOUT=0, HRESP=1; ERR2 drives HREADYOUT=1, HRESP=1. There is no memory access.
REQ-022 In ACCESS, HREADYOUT SHALL be 0 for WAIT_STATES cycles, then 1 for one cycle with HRESP=0. With WAIT_STATES=0, HREADYOUT is 1 in the first data-phase cycle.
REQ-023 A write SHALL update memory at the clock edge ending the data phase, using HWDATA and only the byte lanes selected by HSIZE and the registered offset[1:0].
REQ-024 A read SHALL drive the word at offset[9:2] on HRDATA in the cycle where HREADYOUT=1. In all other cycles HRDATA SHALL hold its last value.
REQ-025 A read in the data phase that follows a write to the same word SHALL return the newly written data.
REQ-026 Pipelined back-to-back transfers (NON_SEQ then SEQ ...) SHALL sustain one transfer per cycle when WAIT_STATES=0.
REQ-027 While HREADYOUT=0 the block SHALL NOT sample a new address phase.
REQ-028 The memory SHALL wrap modulo MEM_BYTES on offset, so there is no overflow into other slaves.

Reset
REQ-029 While reset=0: state=IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, wait counter=0, registered control cleared.
REQ-030 Reset asserted mid-transfer SHALL abort the transfer; a pending write SHALL NOT be committed.
REQ-031 Memory contents SHALL NOT be cleared by reset. ROM bytes SHALL be initialised at time zero from the package constant ROM_INIT.

Structure
REQ-032 definesPkg SHALL hold the HTRANS enum (IDLE, BUSY, NON_SEQ, SEQ), the HBURST and HSIZE encodings, the HRESP constants OKAY/ERROR, the slave FSM state enum, and ROM_INIT.
REQ-033 One sub-module, slave_mem_array, SHALL implement the byte-lane-writable, word-addressed storage.

Verification
REQ-034 Single write 0xDEADBEEF to offset 0x010, then read 0x010 -> HREADYOUT=1 in every data phase, HRESP=0, HRDATA=0xDEADBEEF.
REQ-035 Write to offset 0x002 (ROM) -> cycle 1: HREADYOUT=0, HRESP=1; cycle 2: HREADYOUT=1, HRESP=1; then a read of 0x000 returns ROM_INIT unchanged.
REQ-036 INCR4 writes 0x1..0x4 at 0x100..0x10C, then INCR4 reads -> data 0x1..0x4 on four consecutive cycles, no wait states.
REQ-037 WAIT_STATES=2, single read -> HREADYOUT low exactly 2 cycles, then high with valid data; HADDR/HWRITE held stable across the wait.
REQ-038 Byte write 0xAB at offset 0x021 over word 0x11223344 -> readback 0x1122AB44. Half-word access at 0x023 -> ERROR response.
REQ-039 Reset asserted during the data phase of a write to 0x040 -> outputs return to reset values immediately and 0x040 keeps its old value.
